// File: rtl/stg1ia_imem.sv
// Instruction-memory responder: fixed-latency read pipeline with flush squash,
// loader write port and a delivered-response counter.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif

module stg1ia_imem #(
   parameter int unsigned WORDS   = 4096,
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned LATENCY = 2
) (
   input  logic                  iw_clk,
   input  logic                  iw_rst,
   input  logic                  iw_flush,
   input  logic                  iw_req_valid,
   input  logic [`SIZE_ADDR-1:0] iw_req_addr,
   input  logic                  iw_ld_we,
   input  logic [`SIZE_ADDR-1:0] iw_ld_addr,
   input  logic [DATA_W-1:0]     iw_ld_data,
   output logic                  ow_rsp_valid,
   output logic [`SIZE_ADDR-1:0] ow_rsp_addr,
   output logic [DATA_W-1:0]     ow_rsp_data,
   output logic                  ow_rsp_err,
   output logic [15:0]           ow_rsp_count
);

   localparam int unsigned AW    = `SIZE_ADDR;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [AW:0] LIMIT = (AW+1)'(WORDS);

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("stg1ia_imem: LATENCY must be in 1..4");
   end

   logic [DATA_W-1:0] mem [WORDS];

   logic              v_q [LATENCY];
   logic              v_d [LATENCY];
   logic [AW-1:0]     a_q [LATENCY];
   logic [AW-1:0]     a_d [LATENCY];
   logic              e_q [LATENCY];
   logic              e_d [LATENCY];
   logic [DATA_W-1:0] d_q [LATENCY];
   logic [DATA_W-1:0] d_d [LATENCY];
   logic [15:0]       count_q;
   logic [15:0]       count_d;

   logic req_oor;
   logic ld_ok;

   assign req_oor = ({1'b0, iw_req_addr} >= LIMIT);
   assign ld_ok   = iw_ld_we && ({1'b0, iw_ld_addr} < LIMIT);

   // Stage 0 reads the array combinationally, so the sampling edge also captures data;
   // the non-blocking array write below makes same-edge read/write return the old word.
   always_comb begin
      v_d[0] = iw_req_valid & ~iw_flush;
      a_d[0] = iw_req_addr;
      e_d[0] = req_oor;
      d_d[0] = req_oor ? '0 : mem[iw_req_addr[IDX_W-1:0]];
      for (int unsigned i = 1; i < LATENCY; i++) begin
         v_d[i] = v_q[i-1] & ~iw_flush;
         a_d[i] = a_q[i-1];
         e_d[i] = e_q[i-1];
         d_d[i] = d_q[i-1];
      end
      count_d = count_q + {15'd0, v_d[LATENCY-1]};
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            v_q[i] <= 1'b0;
            a_q[i] <= '0;
            e_q[i] <= 1'b0;
            d_q[i] <= '0;
         end
         count_q <= '0;
      end else begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            v_q[i] <= v_d[i];
            a_q[i] <= a_d[i];
            e_q[i] <= e_d[i];
            d_q[i] <= d_d[i];
         end
         count_q <= count_d;
      end
   end

   // Array contents survive reset.
   always_ff @(posedge iw_clk) begin
      if (ld_ok) begin
         mem[iw_ld_addr[IDX_W-1:0]] <= iw_ld_data;
      end
   end

   assign ow_rsp_valid = v_q[LATENCY-1];
   assign ow_rsp_addr  = a_q[LATENCY-1];
   assign ow_rsp_data  = d_q[LATENCY-1];
   assign ow_rsp_err   = e_q[LATENCY-1];
   assign ow_rsp_count = count_q;

endmodule

// File: tb/tb_stg1ia_imem.sv
// Self-checking bench for stg1ia_imem: directed scenarios plus randomized traffic
// checked against a due-time response queue model.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif

module tb_stg1ia_imem;

   localparam int unsigned WORDS   = 4096;
   localparam int unsigned DATA_W  = 24;
   localparam int unsigned LATENCY = 2;

   logic                  iw_clk = 1'b0;
   logic                  iw_rst;
   logic                  iw_flush;
   logic                  iw_req_valid;
   logic [`SIZE_ADDR-1:0] iw_req_addr;
   logic                  iw_ld_we;
   logic [`SIZE_ADDR-1:0] iw_ld_addr;
   logic [DATA_W-1:0]     iw_ld_data;
   logic                  ow_rsp_valid;
   logic [`SIZE_ADDR-1:0] ow_rsp_addr;
   logic [DATA_W-1:0]     ow_rsp_data;
   logic                  ow_rsp_err;
   logic [15:0]           ow_rsp_count;

   stg1ia_imem #(.WORDS(WORDS), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
      .iw_clk       (iw_clk),
      .iw_rst       (iw_rst),
      .iw_flush     (iw_flush),
      .iw_req_valid (iw_req_valid),
      .iw_req_addr  (iw_req_addr),
      .iw_ld_we     (iw_ld_we),
      .iw_ld_addr   (iw_ld_addr),
      .iw_ld_data   (iw_ld_data),
      .ow_rsp_valid (ow_rsp_valid),
      .ow_rsp_addr  (ow_rsp_addr),
      .ow_rsp_data  (ow_rsp_data),
      .ow_rsp_err   (ow_rsp_err),
      .ow_rsp_count (ow_rsp_count)
   );

   always #5 iw_clk = ~iw_clk;

   typedef struct {
      int                    due;
      logic [`SIZE_ADDR-1:0] a;
      logic [DATA_W-1:0]     d;
      logic                  e;
   } rsp_t;

   rsp_t              pend[$];
   logic [DATA_W-1:0] mem_m [WORDS];
   int                cyc = 0;
   int                n_cmp = 0;
   int                n_bad = 0;
   logic                  exp_v;
   logic [`SIZE_ADDR-1:0] exp_a;
   logic [DATA_W-1:0]     exp_d;
   logic                  exp_e;
   logic [15:0]           exp_cnt;

   // Advance one clock edge, updating the model from the inputs sampled at that edge,
   // then settle to #1 after the edge with the expected outputs for the new cycle.
   task automatic step();
      rsp_t r;
      if (iw_flush === 1'b1) begin
         pend.delete();
      end else if (iw_req_valid === 1'b1) begin
         r.due = cyc + LATENCY;
         r.a   = iw_req_addr;
         r.e   = (int'(iw_req_addr) >= WORDS);
         r.d   = r.e ? '0 : mem_m[int'(iw_req_addr)];
         pend.push_back(r);
      end
      if (iw_ld_we === 1'b1 && int'(iw_ld_addr) < WORDS) mem_m[int'(iw_ld_addr)] = iw_ld_data;
      @(posedge iw_clk);
      cyc++;
      exp_v = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         r = pend.pop_front();
         exp_v = 1'b1;
         exp_a = r.a;
         exp_d = r.d;
         exp_e = r.e;
         exp_cnt = exp_cnt + 16'd1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      iw_flush = 1'b0; iw_req_valid = 1'b0; iw_req_addr = '0;
      iw_ld_we = 1'b0; iw_ld_addr = '0; iw_ld_data = '0;
   endtask

   task automatic load(input int unsigned a, input logic [DATA_W-1:0] d);
      iw_ld_we = 1'b1; iw_ld_addr = a[`SIZE_ADDR-1:0]; iw_ld_data = d;
      step();
      iw_ld_we = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      iw_rst = 1'b1;
      exp_cnt = '0;
      #2;
      n_cmp++;
      if ({ow_rsp_valid, ow_rsp_addr, ow_rsp_data, ow_rsp_err, ow_rsp_count} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b a=%h d=%h e=%b c=%0d, want all 0",
                  ow_rsp_valid, ow_rsp_addr, ow_rsp_data, ow_rsp_err, ow_rsp_count);
      end
      #6 iw_rst = 1'b0;
   endtask

   task automatic test_single();
      load(5, 24'h123456);
      iw_req_valid = 1'b1; iw_req_addr = 16'd5;
      step();
      iw_req_valid = 1'b0; iw_req_addr = 'x;
      n_cmp++;
      if (ow_rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL single_early: valid got %b want 0", ow_rsp_valid);
      end
      step();
      n_cmp++;
      if ({ow_rsp_valid, ow_rsp_addr, ow_rsp_data, ow_rsp_err, ow_rsp_count} !==
          {1'b1, 16'd5, 24'h123456, 1'b0, 16'd1}) begin
         n_bad++;
         $display("FAIL single_rsp: got v=%b a=%0d d=%h e=%b c=%0d want v=1 a=5 d=123456 e=0 c=1",
                  ow_rsp_valid, ow_rsp_addr, ow_rsp_data, ow_rsp_err, ow_rsp_count);
      end
      step();
      n_cmp++;
      if (ow_rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL single_after: valid got %b want 0", ow_rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned seen = 0;
      logic [15:0] c0;
      for (int unsigned i = 0; i < 4; i++) load(i, 24'hA0 + 24'(i));
      c0 = exp_cnt;
      for (int unsigned k = 0; k < 4 + LATENCY + 1; k++) begin
         iw_req_valid = (k < 4);
         iw_req_addr  = 16'(k);
         step();
         n_cmp++;
         if (ow_rsp_valid !== exp_v || ow_rsp_count !== exp_cnt) begin
            n_bad++; $display("FAIL b2b_valid: cyc=%0d got v=%b c=%0d want v=%b c=%0d",
                              cyc, ow_rsp_valid, ow_rsp_count, exp_v, exp_cnt);
         end
         if (exp_v) begin
            n_cmp++;
            if (ow_rsp_data !== 24'hA0 + 24'(seen) || ow_rsp_addr !== 16'(seen) || ow_rsp_err !== 1'b0) begin
               n_bad++; $display("FAIL b2b_data: got a=%0d d=%h e=%b want a=%0d d=%h e=0",
                                 ow_rsp_addr, ow_rsp_data, ow_rsp_err, seen, 24'hA0 + 24'(seen));
            end
            seen++;
         end
      end
      n_cmp++;
      if (ow_rsp_count !== c0 + 16'd4) begin
         n_bad++; $display("FAIL b2b_count: got %0d want %0d", ow_rsp_count, c0 + 16'd4);
      end
   endtask

   task automatic test_flush();
      int unsigned nv = 0;
      for (int unsigned k = 0; k < 3 + LATENCY + 2; k++) begin
         iw_req_valid = (k < 3);
         iw_req_addr  = 16'(k + 1);
         iw_flush     = (k == 1);
         step();
         n_cmp++;
         if (ow_rsp_valid !== exp_v || ow_rsp_count !== exp_cnt) begin
            n_bad++; $display("FAIL flush_valid: cyc=%0d got v=%b c=%0d want v=%b c=%0d",
                              cyc, ow_rsp_valid, ow_rsp_count, exp_v, exp_cnt);
         end
         if (ow_rsp_valid === 1'b1) begin
            nv++;
            n_cmp++;
            if (k != 2 + LATENCY - 1 || ow_rsp_addr !== 16'd3 || ow_rsp_data !== 24'hA3) begin
               n_bad++; $display("FAIL flush_survivor: step=%0d got a=%0d d=%h want step=%0d a=3 d=a3",
                                 k, ow_rsp_addr, ow_rsp_data, 2 + LATENCY - 1);
            end
         end
      end
      iw_flush = 1'b0;
      n_cmp++;
      if (nv != 1) begin
         n_bad++; $display("FAIL flush_count: got %0d responses want 1", nv);
      end
   endtask

   task automatic test_out_of_range();
      load(0, 24'h0F0F0F);
      load(WORDS, 24'hDEAD01);
      for (int unsigned k = 0; k < 2 + LATENCY; k++) begin
         iw_req_valid = (k < 2);
         iw_req_addr  = (k == 0) ? 16'(WORDS) : 16'd0;
         step();
         n_cmp++;
         if (ow_rsp_valid !== exp_v || ow_rsp_count !== exp_cnt) begin
            n_bad++; $display("FAIL oor_valid: cyc=%0d got v=%b c=%0d want v=%b c=%0d",
                              cyc, ow_rsp_valid, ow_rsp_count, exp_v, exp_cnt);
         end
         if (exp_v) begin
            n_cmp++;
            if ({ow_rsp_addr, ow_rsp_data, ow_rsp_err} !==
                ((k == LATENCY - 1) ? {16'(WORDS), 24'h0, 1'b1} : {16'd0, 24'h0F0F0F, 1'b0})) begin
               n_bad++; $display("FAIL oor_rsp: step=%0d got a=%0d d=%h e=%b", k, ow_rsp_addr, ow_rsp_data, ow_rsp_err);
            end
         end
      end
   endtask

   task automatic test_read_first();
      logic [DATA_W-1:0] got[$];
      load(7, 24'h111111);
      for (int unsigned k = 0; k < 2 + LATENCY; k++) begin
         iw_req_valid = (k < 2);
         iw_req_addr  = 16'd7;
         iw_ld_we = (k == 0); iw_ld_addr = 16'd7; iw_ld_data = 24'h000BAD;
         step();
         n_cmp++;
         if (ow_rsp_valid !== exp_v) begin
            n_bad++; $display("FAIL rf_valid: got %b want %b", ow_rsp_valid, exp_v);
         end
         if (ow_rsp_valid === 1'b1) got.push_back(ow_rsp_data);
      end
      iw_ld_we = 1'b0;
      n_cmp++;
      if (got.size() != 2 || got[0] !== 24'h111111 || got[1] !== 24'h000BAD) begin
         n_bad++; $display("FAIL rf_data: got n=%0d first=%h second=%h want 111111 then 000bad",
                           got.size(), (got.size() > 0) ? got[0] : 'x, (got.size() > 1) ? got[1] : 'x);
      end
   endtask

   task automatic test_reset_midstream();
      int unsigned seen = 0;
      iw_req_valid = 1'b1; iw_req_addr = 16'd1; step();
      iw_req_addr = 16'd2; step();
      iw_req_valid = 1'b0;
      #2 iw_rst = 1'b1;
      #1;
      pend.delete(); exp_cnt = '0;
      n_cmp++;
      if ({ow_rsp_valid, ow_rsp_addr, ow_rsp_data, ow_rsp_err, ow_rsp_count} !== '0) begin
         n_bad++; $display("FAIL midreset_outputs: got v=%b a=%h d=%h e=%b c=%0d want all 0",
                           ow_rsp_valid, ow_rsp_addr, ow_rsp_data, ow_rsp_err, ow_rsp_count);
      end
      #2 iw_rst = 1'b0;
      for (int unsigned k = 0; k < 2 * LATENCY + 3; k++) begin
         iw_req_valid = (k == LATENCY + 1);
         iw_req_addr  = 16'd5;
         step();
         n_cmp++;
         if (ow_rsp_valid !== exp_v || ow_rsp_count !== exp_cnt) begin
            n_bad++; $display("FAIL midreset_after: step=%0d got v=%b c=%0d want v=%b c=%0d",
                              k, ow_rsp_valid, ow_rsp_count, exp_v, exp_cnt);
         end
         if (ow_rsp_valid === 1'b1) begin
            seen++;
            n_cmp++;
            if (ow_rsp_data !== 24'h123456 || ow_rsp_addr !== 16'd5) begin
               n_bad++; $display("FAIL midreset_mem: got a=%0d d=%h want a=5 d=123456", ow_rsp_addr, ow_rsp_data);
            end
         end
      end
      n_cmp++;
      if (seen != 1) begin
         n_bad++; $display("FAIL midreset_nresp: got %0d want 1", seen);
      end
   endtask

   task automatic test_random();
      for (int unsigned i = 0; i < 64; i++) load(i, 24'($urandom));
      for (int unsigned k = 0; k < 600; k++) begin
         iw_req_valid = ($urandom_range(0, 3) != 0) && (k < 590);
         if (iw_req_valid)
            iw_req_addr = ($urandom_range(0, 15) == 0) ? 16'(WORDS + $urandom_range(0, 60000))
                                                       : 16'($urandom_range(0, 63));
         else
            iw_req_addr = 'x;
         iw_flush   = ($urandom_range(0, 15) == 0);
         iw_ld_we   = ($urandom_range(0, 3) == 0);
         iw_ld_addr = ($urandom_range(0, 7) == 0) ? 16'(WORDS + $urandom_range(0, 60000))
                                                  : 16'($urandom_range(0, 63));
         iw_ld_data = 24'($urandom);
         step();
         n_cmp++;
         if (ow_rsp_valid !== exp_v || ow_rsp_count !== exp_cnt) begin
            n_bad++; $display("FAIL rand_valid: cyc=%0d got v=%b c=%0d want v=%b c=%0d",
                              cyc, ow_rsp_valid, ow_rsp_count, exp_v, exp_cnt);
         end
         if (exp_v) begin
            n_cmp++;
            if ({ow_rsp_addr, ow_rsp_data, ow_rsp_err} !== {exp_a, exp_d, exp_e}) begin
               n_bad++; $display("FAIL rand_rsp: cyc=%0d got a=%h d=%h e=%b want a=%h d=%h e=%b",
                                 cyc, ow_rsp_addr, ow_rsp_data, ow_rsp_err, exp_a, exp_d, exp_e);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_flush();
      test_out_of_range();
      test_read_first();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
